// File: rtl/lfsr_pkg.sv
// Shared definitions for the team 8-bit LFSR: taps, next-state function,
// checker state encoding and default lock/miss thresholds.
package lfsr_pkg;

  localparam int LFSR_WIDTH = 8;

  // Feedback taps r[7], r[3], r[2], r[0]
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 8'b1000_1101;

  localparam int LOCK_COUNT_DEFAULT = 4;
  localparam int MISS_LIMIT_DEFAULT = 3;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOCKED = 2'd1
  } chk_state_t;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] r);
    return {r[LFSR_WIDTH-2:0], ^(r & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Locks onto an incoming LFSR sample stream, then flags and counts mismatches,
// dropping back to hunting after MISS_LIMIT consecutive misses.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = LOCK_COUNT_DEFAULT,
  parameter int MISS_LIMIT = MISS_LIMIT_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [LFSR_WIDTH-1:0] sample,
  input  logic                  clear_count,
  output logic                  locked,
  output logic                  error,
  output logic                  lost,
  output logic [15:0]           err_count,
  output logic [1:0]            state
);

  localparam logic [4:0] LOCK_TARGET = 5'(LOCK_COUNT);
  localparam logic [4:0] MISS_TARGET = 5'(MISS_LIMIT);

  chk_state_t            state_q, state_d;
  logic [LFSR_WIDTH-1:0] predicted_q, predicted_d;
  logic [3:0]            match_run_q, match_run_d;
  logic [3:0]            miss_run_q, miss_run_d;
  logic                  have_seed_q, have_seed_d;
  logic [15:0]           err_count_q, err_count_d;
  logic                  error_d, lost_d, err_inc;
  logic [4:0]            match_inc, miss_inc;

  assign match_inc = {1'b0, match_run_q} + 5'd1;
  assign miss_inc  = {1'b0, miss_run_q} + 5'd1;

  always_comb begin
    state_d     = state_q;
    predicted_d = predicted_q;
    match_run_d = match_run_q;
    miss_run_d  = miss_run_q;
    have_seed_d = have_seed_q;
    error_d     = 1'b0;
    lost_d      = 1'b0;
    err_inc     = 1'b0;

    if (sample_valid) begin
      case (state_q)
        HUNT: begin
          // Zero is the LFSR lock-up value and can never be a valid seed
          if (sample != '0) begin
            predicted_d = lfsr_next(sample);
            if (have_seed_q && (sample == predicted_q)) begin
              match_run_d = match_inc[3:0];
              if (match_inc == LOCK_TARGET) begin
                state_d    = LOCKED;
                miss_run_d = 4'd0;
              end
            end else begin
              have_seed_d = 1'b1;
              match_run_d = 4'd0;
            end
          end
        end
        LOCKED: begin
          // Free-run the prediction so an isolated bit error never resyncs us
          predicted_d = lfsr_next(predicted_q);
          if (sample == predicted_q) begin
            miss_run_d = 4'd0;
          end else begin
            error_d    = 1'b1;
            err_inc    = 1'b1;
            miss_run_d = miss_inc[3:0];
            if (miss_inc == MISS_TARGET) begin
              state_d     = HUNT;
              lost_d      = 1'b1;
              have_seed_d = 1'b0;
              match_run_d = 4'd0;
              miss_run_d  = 4'd0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    err_count_d = err_count_q;
    if (clear_count) begin
      err_count_d = 16'd0;
    end else if (err_inc && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= HUNT;
      predicted_q <= '0;
      match_run_q <= 4'd0;
      miss_run_q  <= 4'd0;
      have_seed_q <= 1'b0;
      err_count_q <= 16'd0;
      locked      <= 1'b0;
      error       <= 1'b0;
      lost        <= 1'b0;
    end else begin
      state_q     <= state_d;
      predicted_q <= predicted_d;
      match_run_q <= match_run_d;
      miss_run_q  <= miss_run_d;
      have_seed_q <= have_seed_d;
      err_count_q <= err_count_d;
      locked      <= (state_d == LOCKED);
      error       <= error_d;
      lost        <= lost_d;
    end
  end

  assign err_count = err_count_q;
  assign state     = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a behavioural model pushes expected outputs
// per driven cycle; each scenario task pops and compares after the clock edge.
module tb_lfsr_checker;

  localparam int LOCK_N = 4;
  localparam int MISS_N = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [7:0]  sample;
  logic        clear_count;
  logic        locked, error, lost;
  logic [15:0] err_count;
  logic [1:0]  state;

  logic        s_reset, s_valid, s_clear;
  logic [7:0]  s_sample;
  logic        s_locked, s_error, s_lost;
  logic [15:0] s_err_count;
  logic [1:0]  s_state;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]  st;
    logic        lk;
    logic        er;
    logic        ls;
    logic [15:0] cnt;
  } obs_t;

  obs_t sb[$];

  logic [7:0]  m_pred;
  int          m_match, m_miss;
  logic        m_seed, m_locked, m_err_p, m_lost_p;
  logic [15:0] m_cnt;

  always #5 clock = ~clock;

  lfsr_checker dut (
    .clock(clock), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .clear_count(clear_count), .locked(locked), .error(error), .lost(lost),
    .err_count(err_count), .state(state)
  );

  // Wider miss limit so the saturation run never has to relock
  lfsr_checker #(.LOCK_COUNT(4), .MISS_LIMIT(15)) dut_sat (
    .clock(clock), .reset(s_reset), .sample_valid(s_valid), .sample(s_sample),
    .clear_count(s_clear), .locked(s_locked), .error(s_error), .lost(s_lost),
    .err_count(s_err_count), .state(s_state)
  );

  function automatic logic [7:0] ref_next(input logic [7:0] r);
    logic fb;
    fb = r[7] ^ r[3] ^ r[2] ^ r[0];
    return (r << 1) | {7'd0, fb};
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.st  = state;
    o.lk  = locked;
    o.er  = error;
    o.ls  = lost;
    o.cnt = err_count;
    return o;
  endfunction

  task automatic model_update(input logic rst_n, input logic v, input logic [7:0] s,
                              input logic clr);
    logic inc;
    inc      = 1'b0;
    m_err_p  = 1'b0;
    m_lost_p = 1'b0;
    if (!rst_n) begin
      m_pred = 8'h00; m_match = 0; m_miss = 0; m_seed = 1'b0;
      m_locked = 1'b0; m_cnt = 16'h0000;
    end else begin
      if (v && !m_locked && s != 8'h00) begin
        if (m_seed && s == m_pred) begin
          m_match = m_match + 1;
          if (m_match == LOCK_N) begin
            m_locked = 1'b1;
            m_miss   = 0;
          end
        end else begin
          m_seed  = 1'b1;
          m_match = 0;
        end
        m_pred = ref_next(s);
      end else if (v && m_locked) begin
        if (s != m_pred) begin
          m_err_p = 1'b1;
          inc     = 1'b1;
          m_miss  = m_miss + 1;
          if (m_miss == MISS_N) begin
            m_locked = 1'b0; m_lost_p = 1'b1; m_seed = 1'b0; m_match = 0; m_miss = 0;
          end
        end else begin
          m_miss = 0;
        end
        m_pred = ref_next(m_pred);
      end
      if (clr) m_cnt = 16'h0000;
      else if (inc && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic v, input logic [7:0] s,
                               input logic clr);
    obs_t e;
    reset = rst_n; sample_valid = v; sample = s; clear_count = clr;
    model_update(rst_n, v, s, clr);
    e.st  = {1'b0, m_locked};
    e.lk  = m_locked;
    e.er  = m_err_p;
    e.ls  = m_lost_p;
    e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, exp_v;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h0F, 1'b0);
      got = observe(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) begin
        bad++; $display("[TB] FAIL reset[%0d]: got=%h expected=%h", i, got, exp_v);
      end
    end
    total++;
    if ({state, locked, error, lost, err_count} !== 21'd0) begin
      bad++; $display("[TB] FAIL reset_zero: got=%h expected=0", {state, locked, err_count});
    end
  endtask

  task automatic test_lock();
    logic [7:0] seq [5] = '{8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    obs_t got, exp_v;
    foreach (seq[i]) begin
      applyStimulus(1'b1, 1'b1, seq[i], 1'b0);
      got = observe(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) begin
        bad++; $display("[TB] FAIL lock[%0d]: got=%h expected=%h", i, got, exp_v);
      end
    end
    total++;
    if (locked !== 1'b1 || state !== 2'd1 || err_count !== 16'd0) begin
      bad++; $display("[TB] FAIL lock_final: got lk=%b st=%0d cnt=%0d expected 1/1/0",
                      locked, state, err_count);
    end
  endtask

  task automatic test_single_error();
    logic [7:0] seq [4] = '{8'h00, 8'hFD, 8'hFA, 8'h55};
    logic       vld [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    obs_t got, exp_v;
    foreach (seq[i]) begin
      applyStimulus(1'b1, vld[i], seq[i], 1'b0);
      got = observe(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) begin
        bad++; $display("[TB] FAIL single_err[%0d]: got=%h expected=%h", i, got, exp_v);
      end
    end
    total++;
    if (err_count !== 16'd1 || locked !== 1'b1) begin
      bad++; $display("[TB] FAIL single_err_final: got cnt=%0d lk=%b expected 1/1",
                      err_count, locked);
    end
  endtask

  task automatic test_loss();
    obs_t got, exp_v;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) applyStimulus(1'b1, (i < 4), 8'hAA, 1'b0);
      got = observe(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) begin
        bad++; $display("[TB] FAIL loss[%0d]: got=%h expected=%h", i, got, exp_v);
      end
      if (i == 3) begin
        total++;
        if (lost !== 1'b1 || locked !== 1'b0 || err_count !== 16'd3) begin
          bad++; $display("[TB] FAIL loss_edge: got ls=%b lk=%b cnt=%0d expected 1/0/3",
                          lost, locked, err_count);
        end
      end
    end
  endtask

  task automatic test_hunt_reseed();
    logic [7:0] seq [8] = '{8'h0F, 8'h1F, 8'h00, 8'h55, 8'hAB, 8'h57, 8'hAF, 8'h5F};
    logic [7:0] p;
    obs_t got, exp_v;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 13; i++) begin
      if (i < 8) begin
        p = seq[i];
      end else if (i == 10) begin
        p = 8'h00;
      end else begin
        p = ref_next(i == 11 ? ref_next(8'h5F) : (i == 8 ? 8'h5F : sample));
        if (i == 12) p = ref_next(ref_next(ref_next(ref_next(8'h5F))));
        if (i == 11) p = ref_next(ref_next(ref_next(8'h5F)));
        if (i == 9)  p = ref_next(ref_next(8'h5F));
      end
      applyStimulus(1'b1, 1'b1, p, 1'b0);
      got = observe(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) begin
        bad++; $display("[TB] FAIL hunt[%0d]: got=%h expected=%h", i, got, exp_v);
      end
    end
    total++;
    if (locked !== 1'b1 || err_count !== 16'd0) begin
      bad++; $display("[TB] FAIL hunt_final: got lk=%b cnt=%0d expected 1/0", locked, err_count);
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, exp_v;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, (i % 2 == 0) ? ~m_pred : m_pred, 1'b0);
      got = observe(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) begin
        bad++; $display("[TB] FAIL pre_reset[%0d]: got=%h expected=%h", i, got, exp_v);
      end
    end
    applyStimulus(1'b1, 1'b1, ~m_pred, 1'b1);
    got = observe(); exp_v = sb.pop_front(); total++;
    if (got !== exp_v || error !== 1'b1 || err_count !== 16'd0) begin
      bad++; $display("[TB] FAIL clear_vs_err: got=%h expected=%h", got, exp_v);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, (i % 2 == 0) ? ~m_pred : m_pred, 1'b0);
      void'(sb.pop_front());
    end
    total++;
    if (err_count !== 16'd5 || locked !== 1'b1) begin
      bad++; $display("[TB] FAIL preload5: got cnt=%0d lk=%b expected 5/1", err_count, locked);
    end
    applyStimulus(1'b0, 1'b1, ~m_pred, 1'b1);
    got = observe(); exp_v = sb.pop_front(); total++;
    if (got !== exp_v || got !== '0) begin
      bad++; $display("[TB] FAIL reset_mid: got=%h expected=%h", got, exp_v);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] p;
    int errs, miss;
    s_valid = 1'b0; s_sample = 8'h00; s_clear = 1'b0; s_reset = 1'b0;
    @(posedge clock); #1;
    s_reset = 1'b1; s_valid = 1'b1;
    p = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      s_sample = p; p = ref_next(p);
      @(posedge clock); #1;
    end
    errs = 0; miss = 0;
    while (errs < 65535) begin
      if (miss == 14) begin s_sample = p; miss = 0; end
      else begin s_sample = ~p; miss++; errs++; end
      p = ref_next(p);
      @(posedge clock); #1;
    end
    total++;
    if (s_err_count !== 16'hFFFF || s_locked !== 1'b1) begin
      bad++; $display("[TB] FAIL sat_preload: got cnt=%h lk=%b expected FFFF/1",
                      s_err_count, s_locked);
    end
    if (miss == 14) begin s_sample = p; p = ref_next(p); @(posedge clock); #1; end
    s_sample = ~p; p = ref_next(p);
    @(posedge clock); #1;
    total++;
    if (s_err_count !== 16'hFFFF || s_error !== 1'b1) begin
      bad++; $display("[TB] FAIL sat_hold: got cnt=%h er=%b expected FFFF/1", s_err_count, s_error);
    end
    s_sample = ~p; s_clear = 1'b1;
    @(posedge clock); #1;
    total++;
    if (s_err_count !== 16'h0000 || s_error !== 1'b1) begin
      bad++; $display("[TB] FAIL sat_clear: got cnt=%h er=%b expected 0000/1", s_err_count, s_error);
    end
    s_valid = 1'b0; s_clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0; sample_valid = 1'b0; sample = 8'h00; clear_count = 1'b0;
    s_reset = 1'b0; s_valid = 1'b0; s_sample = 8'h00; s_clear = 1'b0;
    m_pred = 8'h00; m_match = 0; m_miss = 0; m_seed = 1'b0; m_locked = 1'b0;
    m_err_p = 1'b0; m_lost_p = 1'b0; m_cnt = 16'h0000;
    test_reset();
    test_lock();
    test_single_error();
    test_loss();
    test_hunt_reseed();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
